// File: rtl/and4_result_checker_pkg.sv
// Shared definitions for the Bitwise_And4 result checker family.
package and4_result_checker_pkg;

  typedef enum logic [1:0] {
    VERDICT_IDLE = 2'b00,
    VERDICT_PASS = 2'b01,
    VERDICT_FAIL = 2'b10
  } verdict_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int LAT_MAX       = 7;

endpackage

// File: rtl/and4_delay_line.sv
// Valid+data shift register of STAGES depth; STAGES=0 is a combinational bypass.
module and4_delay_line
  import and4_result_checker_pkg::*;
#(
  parameter int DATA_W = 3 * DEFAULT_WIDTH,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, flush};
    assign out_vld     = in_vld;
    assign out_data    = in_data;
  end else begin : g_shift
    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p [STAGES];

    // Only the valid bits carry state that matters; stale data is never qualified.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '0;
      end else if (flush) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= in_vld;
        for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      data_p[0] <= in_data;
      for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];
  end

endmodule

// File: rtl/and4_result_checker.sv
// Monitors the AND datapath: compares c_obs against a & b delayed by LAT cycles,
// keeping saturating counters, a sticky verdict and the first failing vector.
module and4_result_checker
  import and4_result_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c_obs,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [1:0]       verdict,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs
);

  localparam int VEC_W = 3 * WIDTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : CNT_W'(v + 1'b1);
  endfunction

  logic [VEC_W-1:0] vec_p0;
  logic [VEC_W-1:0] vec_pn;
  logic             vld_pn;
  logic [WIDTH-1:0] a_pn, b_pn, exp_pn;
  logic             cmp_vld;
  logic             mismatch;
  verdict_t         state_q, state_d;

  // Stage 0: operands and expected result enter the delay line.
  assign vec_p0 = {a, b, a & b};

  and4_delay_line #(
    .DATA_W (VEC_W),
    .STAGES (LAT)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .in_vld   (in_valid),
    .in_data  (vec_p0),
    .out_vld  (vld_pn),
    .out_data (vec_pn)
  );

  // Stage LAT: compare against c_obs; clear suppresses a compare due this cycle.
  assign a_pn     = vec_pn[VEC_W-1 -: WIDTH];
  assign b_pn     = vec_pn[2*WIDTH-1 -: WIDTH];
  assign exp_pn   = vec_pn[WIDTH-1:0];
  assign cmp_vld  = vld_pn & ~clear;
  assign mismatch = cmp_vld && (c_obs != exp_pn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_count <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      first_exp   <= '0;
      first_obs   <= '0;
    end else if (clear) begin
      check_count <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      first_exp   <= '0;
      first_obs   <= '0;
    end else if (cmp_vld) begin
      check_count <= sat_inc(check_count);
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        err_flag  <= 1'b1;
        if (err_count == '0) begin
          first_a   <= a_pn;
          first_b   <= b_pn;
          first_exp <= exp_pn;
          first_obs <= c_obs;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= VERDICT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = VERDICT_IDLE;
    end else if (cmp_vld) begin
      unique case (state_q)
        VERDICT_IDLE: state_d = mismatch ? VERDICT_FAIL : VERDICT_PASS;
        VERDICT_PASS: if (mismatch) state_d = VERDICT_FAIL;
        VERDICT_FAIL: state_d = VERDICT_FAIL;
        default:      state_d = VERDICT_IDLE;
      endcase
    end
  end

  assign verdict = state_q;

endmodule

// File: tb/tb_and4_result_checker.sv
// Directed bench: four checker instances (LAT=1, LAT=3, LAT=1 with 4-bit counters, LAT=0).
module tb_and4_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [4];
  logic        clear_s [4];
  logic        iv_s    [4];
  logic [3:0]  a_s     [4];
  logic [3:0]  b_s     [4];
  logic [3:0]  c_s     [4];
  logic [15:0] cc_s    [4];
  logic [15:0] ec_s    [4];
  logic        flag_s  [4];
  logic [1:0]  verd_s  [4];
  logic [3:0]  fa_s    [4];
  logic [3:0]  fb_s    [4];
  logic [3:0]  fe_s    [4];
  logic [3:0]  fo_s    [4];
  logic [3:0]  cc_sat, ec_sat;

  assign cc_s[2] = {12'h000, cc_sat};
  assign ec_s[2] = {12'h000, ec_sat};

  int checks = 0;
  int passes = 0;

  and4_result_checker #(.WIDTH(4), .LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst(rst_s[0]), .clear(clear_s[0]), .in_valid(iv_s[0]),
    .a(a_s[0]), .b(b_s[0]), .c_obs(c_s[0]),
    .check_count(cc_s[0]), .err_count(ec_s[0]), .err_flag(flag_s[0]), .verdict(verd_s[0]),
    .first_a(fa_s[0]), .first_b(fb_s[0]), .first_exp(fe_s[0]), .first_obs(fo_s[0]));

  and4_result_checker #(.WIDTH(4), .LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst(rst_s[1]), .clear(clear_s[1]), .in_valid(iv_s[1]),
    .a(a_s[1]), .b(b_s[1]), .c_obs(c_s[1]),
    .check_count(cc_s[1]), .err_count(ec_s[1]), .err_flag(flag_s[1]), .verdict(verd_s[1]),
    .first_a(fa_s[1]), .first_b(fb_s[1]), .first_exp(fe_s[1]), .first_obs(fo_s[1]));

  and4_result_checker #(.WIDTH(4), .LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst_s[2]), .clear(clear_s[2]), .in_valid(iv_s[2]),
    .a(a_s[2]), .b(b_s[2]), .c_obs(c_s[2]),
    .check_count(cc_sat), .err_count(ec_sat), .err_flag(flag_s[2]), .verdict(verd_s[2]),
    .first_a(fa_s[2]), .first_b(fb_s[2]), .first_exp(fe_s[2]), .first_obs(fo_s[2]));

  and4_result_checker #(.WIDTH(4), .LAT(0), .CNT_W(16)) u_lat0 (
    .clk(clk), .rst(rst_s[3]), .clear(clear_s[3]), .in_valid(iv_s[3]),
    .a(a_s[3]), .b(b_s[3]), .c_obs(c_s[3]),
    .check_count(cc_s[3]), .err_count(ec_s[3]), .err_flag(flag_s[3]), .verdict(verd_s[3]),
    .first_a(fa_s[3]), .first_b(fb_s[3]), .first_exp(fe_s[3]), .first_obs(fo_s[3]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one instance's inputs at a falling edge, then wait for the next one.
  task automatic drive(input int k, input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] cv, input logic clr);
    iv_s[k]    = v;
    a_s[k]     = av;
    b_s[k]     = bv;
    c_s[k]     = cv;
    clear_s[k] = clr;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_s[k] = 1'b1; clear_s[k] = 1'b0; iv_s[k] = 1'b0;
      a_s[k] = 4'h0; b_s[k] = 4'h0; c_s[k] = 4'h0;
    end
    c_s[3] = 4'bxxxx;
    @(negedge clk);
    @(negedge clk);

    chk("rst_check_count", cc_s[0], 16'd0);
    chk("rst_err_count",   ec_s[0], 16'd0);
    chk("rst_err_flag",    16'(flag_s[0]), 16'd0);
    chk("rst_verdict",     16'(verd_s[0]), 16'd0);
    chk("rst_first_a",     16'(fa_s[0]), 16'd0);
    chk("rst_first_b",     16'(fb_s[0]), 16'd0);
    chk("rst_first_exp",   16'(fe_s[0]), 16'd0);
    chk("rst_first_obs",   16'(fo_s[0]), 16'd0);
    for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;

    // LAT=0: X on c_obs while idle is ignored
    drive(3, 1'b0, 4'h0, 4'h0, 4'bxxxx, 1'b0);
    drive(3, 1'b0, 4'h0, 4'h0, 4'bxxxx, 1'b0);
    chk("lat0_idle_count",   cc_s[3], 16'd0);
    chk("lat0_idle_verdict", 16'(verd_s[3]), 16'd0);
    drive(3, 1'b1, 4'hF, 4'hB, 4'hB, 1'b0);
    chk("lat0_pass_count",   cc_s[3], 16'd1);
    chk("lat0_pass_verdict", 16'(verd_s[3]), 16'd1);
    drive(3, 1'b1, 4'h3, 4'hE, 4'h3, 1'b0);
    drive(3, 1'b0, 4'h0, 4'h0, 4'bxxxx, 1'b0);
    chk("lat0_fail_errs",    ec_s[3], 16'd1);
    chk("lat0_fail_verdict", 16'(verd_s[3]), 16'd2);
    chk("lat0_fail_obs",     16'(fo_s[3]), 16'h3);

    // LAT=1: five back-to-back matching vectors
    drive(0, 1'b1, 4'b0000, 4'b1110, 4'b0000, 1'b0);
    drive(0, 1'b1, 4'b0100, 4'b1110, 4'b0000, 1'b0);
    drive(0, 1'b1, 4'b0011, 4'b1110, 4'b0100, 1'b0);
    drive(0, 1'b1, 4'b0001, 4'b1011, 4'b0010, 1'b0);
    drive(0, 1'b1, 4'b1111, 4'b1011, 4'b0001, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b1011, 1'b0);
    chk("match_count",   cc_s[0], 16'd5);
    chk("match_errs",    ec_s[0], 16'd0);
    chk("match_verdict", 16'(verd_s[0]), 16'd1);
    chk("match_flag",    16'(flag_s[0]), 16'd0);

    // single fault, then a second one that must not disturb the capture
    drive(0, 1'b1, 4'b0011, 4'b1110, 4'b0000, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    chk("fault1_count",   cc_s[0], 16'd6);
    chk("fault1_errs",    ec_s[0], 16'd1);
    chk("fault1_verdict", 16'(verd_s[0]), 16'd2);
    chk("fault1_flag",    16'(flag_s[0]), 16'd1);
    chk("fault1_first_a", 16'(fa_s[0]), 16'h3);
    chk("fault1_first_b", 16'(fb_s[0]), 16'hE);
    chk("fault1_first_exp", 16'(fe_s[0]), 16'h2);
    chk("fault1_first_obs", 16'(fo_s[0]), 16'h3);
    drive(0, 1'b1, 4'b1111, 4'b1011, 4'b0000, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    chk("fault2_errs",      ec_s[0], 16'd2);
    chk("fault2_count",     cc_s[0], 16'd7);
    chk("fault2_first_a",   16'(fa_s[0]), 16'h3);
    chk("fault2_first_exp", 16'(fe_s[0]), 16'h2);
    chk("fault2_first_obs", 16'(fo_s[0]), 16'h3);

    // clear collides with a mismatching compare
    drive(0, 1'b1, 4'b0011, 4'b1110, 4'b0000, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1);
    chk("clr_count",   cc_s[0], 16'd0);
    chk("clr_errs",    ec_s[0], 16'd0);
    chk("clr_verdict", 16'(verd_s[0]), 16'd0);
    chk("clr_flag",    16'(flag_s[0]), 16'd0);
    chk("clr_first_a", 16'(fa_s[0]), 16'h0);
    drive(0, 1'b1, 4'b0100, 4'b1110, 4'b0000, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    chk("post_clr_verdict", 16'(verd_s[0]), 16'd1);
    chk("post_clr_count",   cc_s[0], 16'd1);
    // in_valid during clear is dropped
    drive(0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    drive(0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    chk("clr_iv_count",   cc_s[0], 16'd0);
    chk("clr_iv_verdict", 16'(verd_s[0]), 16'd0);

    // LAT=3: one good compare, then async reset with three bad vectors in flight
    drive(1, 1'b1, 4'hF, 4'hB, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'hB, 1'b0);
    chk("lat3_count",   cc_s[1], 16'd1);
    chk("lat3_verdict", 16'(verd_s[1]), 16'd1);
    drive(1, 1'b1, 4'hF, 4'hB, 4'h0, 1'b0);
    drive(1, 1'b1, 4'h3, 4'hE, 4'h0, 1'b0);
    drive(1, 1'b1, 4'h4, 4'hE, 4'h0, 1'b0);
    #1 rst_s[1] = 1'b1;
    iv_s[1] = 1'b0;
    #1;
    chk("arst_count",   cc_s[1], 16'd0);
    chk("arst_verdict", 16'(verd_s[1]), 16'd0);
    chk("arst_errs",    ec_s[1], 16'd0);
    rst_s[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive(1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("arst_late_count",   cc_s[1], 16'd0);
    chk("arst_late_errs",    ec_s[1], 16'd0);
    chk("arst_late_verdict", 16'(verd_s[1]), 16'd0);
    drive(1, 1'b1, 4'hF, 4'hB, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 4'hB, 1'b0);
    chk("resume_count",   cc_s[1], 16'd1);
    chk("resume_verdict", 16'(verd_s[1]), 16'd1);

    // CNT_W=4: 20 mismatching compares saturate both counters
    for (int i = 0; i < 21; i++) drive(2, (i < 20), 4'hF, 4'hB, 4'h0, 1'b0);
    chk("sat_errs",    ec_s[2], 16'h000F);
    chk("sat_count",   cc_s[2], 16'h000F);
    chk("sat_verdict", 16'(verd_s[2]), 16'd2);
    chk("sat_first_exp", 16'(fe_s[2]), 16'hB);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
